// File: rtl/phase_pair_gen.sv
// phase_pair_gen: programmable channel-1/channel-2 phase-pair source.
// Emits wrapped phase samples with a one-cycle data_rdy strobe every PERIOD
// cycles, in the format phasediff consumes. ph1 - ph2 always equals the
// programmed offset, after wrapping.
module phase_pair_gen #(
    parameter int unsigned W      = 19,
    parameter int unsigned PERIOD = 20,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     phase0,
    input  logic [W-1:0]     step,
    input  logic [W-1:0]     offset,
    input  logic [CNT_W-1:0] n_samples,
    output logic             data_rdy,
    output logic [W-1:0]     out_phase1,
    output logic [W-1:0]     out_phase2,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PCNT_W = $clog2(PERIOD + 1);

    // +180 and 360 degrees in Q(W-10).10, held in W+1 bits
    localparam logic signed [W:0] HALF = (W+1)'(32'd184320);
    localparam logic signed [W:0] FULL = (W+1)'(32'd368640);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    // Sign-extend a phase word by one bit so sums/differences cannot overflow.
    function automatic logic signed [W:0] sx(input logic [W-1:0] a);
        return $signed({a[W-1], a});
    endfunction

    // Fold a W+1-bit value into [-180, +180); operands are pre-wrapped so a
    // single correction always lands in range.
    function automatic logic [W-1:0] wrap(input logic signed [W:0] x);
        logic signed [W:0] y;
        if (x >= HALF) begin
            y = x - FULL;
        end else if (x < -HALF) begin
            y = x + FULL;
        end else begin
            y = x;
        end
        return y[W-1:0];
    endfunction

    logic [1:0]        state_q,  state_d;
    logic [W-1:0]      ph_q,     ph_d;
    logic [W-1:0]      st_q,     st_d;
    logic [W-1:0]      of_q,     of_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [PCNT_W-1:0] pcnt_q,   pcnt_d;
    logic              rdy_q,    rdy_d;
    logic [W-1:0]      p1_q,     p1_d;
    logic [W-1:0]      p2_q,     p2_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic [W-1:0]      src_ph;
    logic [W-1:0]      src_st;
    logic [W-1:0]      src_of;
    logic [CNT_W-1:0]  src_cnt;
    logic              do_emit;

    // Sample source: the wrapped inputs when launching from IDLE, else the latched run state.
    always_comb begin
        src_ph  = ph_q;
        src_st  = st_q;
        src_of  = of_q;
        src_cnt = cnt_q;
        if (state_q == S_IDLE) begin
            src_ph  = wrap(sx(phase0));
            src_st  = wrap(sx(step));
            src_of  = wrap(sx(offset));
            src_cnt = n_samples;
        end
    end

    // Next-state and registered-output logic; outputs follow the next state so they align with it.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        st_d    = st_q;
        of_d    = of_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        rdy_d   = 1'b0;
        p1_d    = p1_q;
        p2_d    = p2_q;
        do_emit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ph_d  = src_ph;
                    st_d  = src_st;
                    of_d  = src_of;
                    cnt_d = n_samples;
                    if (n_samples != '0) begin
                        do_emit = 1'b1;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_EMIT: begin
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_WAIT;
                    pcnt_d  = PCNT_W'(PERIOD - 1);
                end
            end
            S_WAIT: begin
                if (pcnt_q == PCNT_W'(1)) begin
                    do_emit = 1'b1;
                end else begin
                    pcnt_d = pcnt_q - PCNT_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Emit one sample and advance the channel-1 accumulator.
        if (do_emit) begin
            state_d = S_EMIT;
            rdy_d   = 1'b1;
            p1_d    = src_ph;
            p2_d    = wrap(sx(src_ph) - sx(src_of));
            ph_d    = wrap(sx(src_ph) + sx(src_st));
            cnt_d   = src_cnt - CNT_W'(1);
            pcnt_d  = '0;
        end

        busy_d = (state_d == S_EMIT) || (state_d == S_WAIT);
        done_d = (state_d == S_FIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            st_q    <= '0;
            of_q    <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            rdy_q   <= 1'b0;
            p1_q    <= '0;
            p2_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            st_q    <= st_d;
            of_q    <= of_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            rdy_q   <= rdy_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_rdy   = rdy_q;
    assign out_phase1 = p1_q;
    assign out_phase2 = p2_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
